uart_rx: RTL and testbench

- 8N1 UART receiver that turns the serial line into one byte plus a one-cycle strobe.
- It sits directly upstream of the seven-segment display driver and supplies its received_byte/rx_done inputs.
- Runs entirely in the system clock domain, typically 100 MHz.
- The asynchronous rx pin is synchronised internally, and the bit centre is found by counting clocks.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 141 ++++++++++++++
 tb/tb_uart_rx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: receiver state encoding and frame size.
// The transmitter reuses this package, so keep the encodings stable.
package uart_pkg;

  // Payload bits per 8N1 frame
  localparam int DATA_BITS = 8;

  // Width of the data-bit index counter
  localparam int BIT_IDX_W = $clog2(DATA_BITS);

  // Receiver FSM states, 3-bit encoding
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Both flops reset to RST_VAL so the output shows a known level straight out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Capture the asynchronous input and let any metastability settle in the first flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The line is synchronised, a start bit is confirmed at its
// centre, then each data bit and the stop bit are sampled one bit period apart.
// A low stop bit reports a framing error and waits for the line to return high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] received_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0]     BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]     HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] IDX_LAST  = BIT_IDX_W'(DATA_BITS - 1);

  // Below four clocks per bit the half-bit centring has no room to work
  if (CLKS_PER_BIT < 4) begin : g_cfg_check
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  logic                 rx_s;
  uart_state_e          state_r;
  logic [CNT_W-1:0]     clk_cnt_r;
  logic [BIT_IDX_W-1:0] bit_idx_r;
  logic [DATA_BITS-1:0] shreg_r;

  // Idle level is high, so the synchroniser resets high to avoid a false start
  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Frame FSM with bit-period counter, shift register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      clk_cnt_r     <= '0;
      bit_idx_r     <= '0;
      shreg_r       <= '0;
      received_byte <= 8'h00;
      rx_done       <= 1'b0;
      frame_err     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state_r)
        IDLE: begin
          clk_cnt_r <= '0;
          if (!rx_s) begin
            state_r <= START;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end

        START: begin
          if (clk_cnt_r == HALF_LAST) begin
            clk_cnt_r <= '0;
            if (!rx_s) begin
              state_r   <= DATA;
              bit_idx_r <= '0;
            end else begin
              // Line went back high before mid-start: treat as a glitch
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_W'(1);
          end
        end

        DATA: begin
          if (clk_cnt_r == BIT_LAST) begin
            clk_cnt_r          <= '0;
            shreg_r[bit_idx_r] <= rx_s;
            if (bit_idx_r == IDX_LAST) begin
              state_r <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + BIT_IDX_W'(1);
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_W'(1);
          end
        end

        STOP: begin
          if (clk_cnt_r == BIT_LAST) begin
            clk_cnt_r <= '0;
            if (rx_s) begin
              received_byte <= shreg_r;
              rx_done       <= 1'b1;
              state_r       <= IDLE;
              busy          <= 1'b0;
            end else begin
              // Keep the last good byte; hold off until the line recovers
              frame_err <= 1'b1;
              state_r   <= BREAK;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_W'(1);
          end
        end

        BREAK: begin
          clk_cnt_r <= '0;
          if (rx_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            state_r <= BREAK;
          end
        end

        default: begin
          state_r   <= IDLE;
          clk_cnt_r <= '0;
          bit_idx_r <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 10 clocks per bit. A queue of expected
// frame outcomes is filled by the line driver and drained by a per-cycle
// comparator; directed scenarios add literal expectations on top.
module tb_uart_rx;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 100_000;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int LAT_NOM   = 97;
  localparam int LAT_TOL   = 2;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] received_byte;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .received_byte (received_byte),
    .rx_done       (rx_done),
    .frame_err     (frame_err),
    .busy          (busy)
  );

  typedef struct {
    logic [7:0] data;
    bit         good;
    int         fall;
  } exp_t;

  exp_t       exp_q[$];
  int         done_cyc_q[$];
  logic [7:0] got_q[$];

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         busy_cnt = 0;
  logic [7:0] model_byte = 8'h00;
  bit         prev_done = 1'b0;
  exp_t       e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to timestamp start edges and strobes
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame; abort_bit >= 0 stops half-way through that data bit
  task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int abort_bit);
    exp_t x;
    x.data = data;
    x.good = stop_ok;
    x.fall = cyc;
    if (abort_bit < 0) exp_q.push_back(x);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      if (i == abort_bit) begin
        tick(CPB / 2);
        return;
      end
      tick(CPB);
    end
    rx = stop_ok;
    tick(CPB);
  endtask

  // Per-cycle comparison of DUT outputs against the expected-outcome queue
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_byte = 8'h00;
        prev_done  = 1'b0;
        chk({received_byte, rx_done, frame_err, busy} == 11'h000, "reset_outputs",
            int'({received_byte, rx_done, frame_err, busy}), 0);
      end else begin
        chk(!(rx_done && frame_err), "done_err_exclusive", int'({rx_done, frame_err}), 0);
        chk(!(rx_done && prev_done), "done_consecutive", int'({prev_done, rx_done}), 1);
        if (busy) busy_cnt++;
        if (rx_done || frame_err) begin
          if (rx_done) begin
            done_cnt++;
            done_cyc_q.push_back(cyc);
            got_q.push_back(received_byte);
            chk(busy == 1'b0, "busy_at_done", int'(busy), 0);
          end else begin
            err_cnt++;
          end
          chk(exp_q.size() > 0, "unexpected_strobe", int'({rx_done, frame_err}), 0);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.good == rx_done, "strobe_kind", int'(rx_done), int'(e.good));
            chk((cyc - e.fall >= LAT_NOM - LAT_TOL) && (cyc - e.fall <= LAT_NOM + LAT_TOL),
                "strobe_latency", cyc - e.fall, LAT_NOM);
            if (e.good) model_byte = e.data;
          end
        end
        chk(received_byte == model_byte, "received_byte", int'(received_byte), int'(model_byte));
        if (exp_q.size() > 0) begin
          chk(cyc - exp_q[0].fall <= LAT_NOM + LAT_TOL, "strobe_timeout",
              cyc - exp_q[0].fall, LAT_NOM);
          if (cyc - exp_q[0].fall > LAT_NOM + LAT_TOL) void'(exp_q.pop_front());
        end
        prev_done = rx_done;
      end
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    int d0;
    int e0;
    int b0;
    int n;
    rst_n = 1'b0;
    rx    = 1'b1;
    tick(5);
    rst_n = 1'b1;
    tick(5);

    // Single good frame 0x7B
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h7B, 1'b1, -1);
    tick(5);
    chk(done_cnt - d0 == 1, "t1_done_count", done_cnt - d0, 1);
    chk(received_byte == 8'h7B, "t1_byte", int'(received_byte), 'h7B);
    chk(err_cnt == e0, "t1_no_err", err_cnt - e0, 0);

    // Back-to-back 0x00 then 0xFF, one stop bit each
    d0 = done_cnt;
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    tick(5);
    chk(done_cnt - d0 == 2, "t2_done_count", done_cnt - d0, 2);
    n = done_cyc_q.size();
    chk(n >= 2, "t2_have_two", n, 2);
    if (n >= 2) begin
      chk((done_cyc_q[n-1] - done_cyc_q[n-2] >= 98) && (done_cyc_q[n-1] - done_cyc_q[n-2] <= 102),
          "t2_spacing", done_cyc_q[n-1] - done_cyc_q[n-2], 100);
      chk(got_q[n-2] == 8'h00, "t2_first_byte", int'(got_q[n-2]), 'h00);
      chk(got_q[n-1] == 8'hFF, "t2_second_byte", int'(got_q[n-1]), 'hFF);
    end

    // Three-cycle glitch must be rejected
    d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(20);
    chk((busy_cnt - b0 > 0) && (busy_cnt - b0 <= 8), "t3_busy_len", busy_cnt - b0, 8);
    chk(done_cnt == d0 && err_cnt == e0, "t3_no_strobe", done_cnt - d0 + err_cnt - e0, 0);
    chk(busy == 1'b0, "t3_idle", int'(busy), 0);

    // Framing error on 0xA5, line held low, then a good 0x3C
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'hA5, 1'b0, -1);
    rx = 1'b0;
    tick(50);
    chk(err_cnt - e0 == 1, "t4_err_count", err_cnt - e0, 1);
    chk(done_cnt == d0, "t4_no_done", done_cnt - d0, 0);
    chk(received_byte == 8'hFF, "t4_byte_held", int'(received_byte), 'hFF);
    chk(busy == 1'b1, "t4_busy_in_break", int'(busy), 1);
    rx = 1'b1;
    tick(CPB);
    send_frame(8'h3C, 1'b1, -1);
    tick(5);
    chk(err_cnt - e0 == 1, "t4_single_err", err_cnt - e0, 1);
    chk(received_byte == 8'h3C, "t4_byte", int'(received_byte), 'h3C);

    // Reset in the middle of 0x55, then a good 0x81
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h55, 1'b1, 4);
    rst_n = 1'b0;
    rx    = 1'b1;
    tick(5);
    chk(received_byte == 8'h00 && !busy, "t5_in_reset", int'({received_byte, busy}), 0);
    rst_n = 1'b1;
    tick(CPB * 12);
    chk(done_cnt == d0 && err_cnt == e0, "t5_no_strobe", done_cnt - d0 + err_cnt - e0, 0);
    send_frame(8'h81, 1'b1, -1);
    tick(5);
    chk(done_cnt - d0 == 1, "t5_done_count", done_cnt - d0, 1);
    chk(received_byte == 8'h81, "t5_byte", int'(received_byte), 'h81);

    // Randomized frames, gaps, framing errors and glitches
    for (int k = 0; k < 40; k++) begin
      logic [7:0] b;
      bit         good;
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 5) != 0);
      send_frame(b, good, -1);
      if (!good) begin
        rx = 1'b0;
        tick($urandom_range(0, 30));
        rx = 1'b1;
        tick($urandom_range(2, 6));
      end else begin
        rx = 1'b1;
        tick($urandom_range(0, 15));
      end
      if ($urandom_range(0, 4) == 0) begin
        rx = 1'b0;
        tick($urandom_range(1, 3));
        rx = 1'b1;
        tick(12);
      end
    end

    rx = 1'b1;
    tick(120);
    chk(exp_q.size() == 0, "pending_at_end", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
